// File: rtl/lcd_frame_sched_if.sv
// Bus bundle for lcd_frame_sched: LCD driver request/pixel path plus the
// SDRAM read-FIFO strobes. The scheduler sits on the slave side.
interface lcd_frame_sched_if;
  logic        lcd_vs;
  logic        data_req;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic [15:0] pixel_data;
  logic [15:0] fifo_q;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        fifo_rd_load;

  modport slave (
    input  lcd_vs, data_req, pixel_xpos, pixel_ypos, fifo_q, fifo_empty,
    output pixel_data, fifo_rd_en, fifo_rd_load
  );

  modport master (
    output lcd_vs, data_req, pixel_xpos, pixel_ypos, fifo_q, fifo_empty,
    input  pixel_data, fifo_rd_en, fifo_rd_load
  );
endinterface

// File: rtl/lcd_frame_sched.sv
// LCD frame/line scheduler: re-arms the SDRAM read FIFO at vsync and centres an
// H_IMG x V_IMG image on the panel. Optional colour-bar source: LCD_TEST_PATTERN_EN.
module lcd_frame_sched #(
  parameter int          H_IMG     = 640,
  parameter int          V_IMG     = 480,
  parameter int          LOAD_CYC  = 4,
  parameter logic [15:0] BG_COLOR  = 16'h0000,
  parameter logic [15:0] ERR_COLOR = 16'hF800
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef LCD_TEST_PATTERN_EN
  input  logic        test_en,
`endif
  input  logic [10:0] h_disp,
  input  logic [10:0] v_disp,
  output logic        frame_err,
  lcd_frame_sched_if.slave bus
);

  localparam logic [11:0] H_IMG_W   = 12'(H_IMG);
  localparam logic [11:0] V_IMG_W   = 12'(V_IMG);
  localparam logic [7:0]  LOAD_LAST = 8'(LOAD_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;
  logic        vs_d1_r, vs_d2_r;
  logic        vs_fall_s;
  logic [10:0] x0_r, y0_r, w_r, h_r;
  logic [19:0] area_r;
  logic [7:0]  load_cnt_r;
  logic [19:0] pix_cnt_r;
  logic [19:0] pix_inc_s;
  logic        frame_err_r;
  logic        win_d1_r, uflow_d1_r;
  logic [11:0] h_diff_s, v_diff_s;
  logic [10:0] x0_s, y0_s, w_s, h_s;
  logic [11:0] x_end_s, y_end_s;
  logic        win_s, in_stream_s, rd_en_s, uflow_s, short_s, load_entry_s;
  logic        test_s;
  logic [15:0] pix_s;

`ifdef LCD_TEST_PATTERN_EN
  localparam int BAR_W = (H_IMG / 8 > 0) ? H_IMG / 8 : 1;

  logic [10:0] rel_x_s;
  logic [2:0]  bar_idx_s;
  logic [15:0] bar_d1_r;
  logic        test_d1_r;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      3'd7:    bar_color = 16'h0000;
      default: bar_color = 16'h0000;
    endcase
  endfunction

  assign test_s = test_en;
`else
  assign test_s = 1'b0;
`endif

  // Origin: 12-bit difference, a set sign bit means the panel is narrower than the image.
  always_comb begin
    h_diff_s = {1'b0, h_disp} - H_IMG_W;
    v_diff_s = {1'b0, v_disp} - V_IMG_W;
    if (h_diff_s[11]) begin
      x0_s = 11'd0;
      w_s  = h_disp;
    end else begin
      x0_s = 11'(h_diff_s >> 1);
      w_s  = H_IMG_W[10:0];
    end
    if (v_diff_s[11]) begin
      y0_s = 11'd0;
      h_s  = v_disp;
    end else begin
      y0_s = 11'(v_diff_s >> 1);
      h_s  = V_IMG_W[10:0];
    end
  end

  assign vs_fall_s = vs_d2_r & ~vs_d1_r;
  assign x_end_s   = {1'b0, x0_r} + {1'b0, w_r};
  assign y_end_s   = {1'b0, y0_r} + {1'b0, h_r};
  assign win_s     = bus.data_req
                   & (bus.pixel_xpos >= x0_r) & ({1'b0, bus.pixel_xpos} < x_end_s)
                   & (bus.pixel_ypos >= y0_r) & ({1'b0, bus.pixel_ypos} < y_end_s);
  assign pix_inc_s = pix_cnt_r + 20'd1;

  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (vs_fall_s) state_nxt_s = ST_LOAD;
        else           state_nxt_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (load_cnt_r == LOAD_LAST) state_nxt_s = ST_STREAM;
        else                         state_nxt_s = ST_LOAD;
      end
      ST_STREAM: begin
        if (vs_fall_s)                          state_nxt_s = ST_LOAD;
        else if (win_s && pix_inc_s == area_r)  state_nxt_s = ST_DONE;
        else                                    state_nxt_s = ST_STREAM;
      end
      ST_DONE: begin
        if (vs_fall_s) state_nxt_s = ST_LOAD;
        else           state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  assign in_stream_s  = (state_r == ST_STREAM);
  assign rd_en_s      = in_stream_s & win_s & ~bus.fifo_empty & ~test_s;
  assign uflow_s      = in_stream_s & win_s & bus.fifo_empty & ~test_s;
  assign short_s      = in_stream_s & vs_fall_s;
  assign load_entry_s = (state_nxt_s == ST_LOAD) & (state_r != ST_LOAD);

  // Vsync history for the falling-edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d1_r <= 1'b0;
      vs_d2_r <= 1'b0;
    end else begin
      vs_d1_r <= bus.lcd_vs;
      vs_d2_r <= vs_d1_r;
    end
  end

  // Window geometry is only sampled at a vsync edge so it is stable for a whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_r   <= 11'd0;
      y0_r   <= 11'd0;
      w_r    <= 11'd0;
      h_r    <= 11'd0;
      area_r <= 20'd0;
    end else if (vs_fall_s) begin
      x0_r   <= x0_s;
      y0_r   <= y0_s;
      w_r    <= w_s;
      h_r    <= h_s;
      area_r <= 20'(w_s) * 20'(h_s);
    end else begin
      x0_r   <= x0_r;
      y0_r   <= y0_r;
      w_r    <= w_r;
      h_r    <= h_r;
      area_r <= area_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      load_cnt_r <= 8'd0;
      pix_cnt_r  <= 20'd0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_LOAD) load_cnt_r <= load_cnt_r + 8'd1;
      else                    load_cnt_r <= 8'd0;
      if (state_r == ST_LOAD)          pix_cnt_r <= 20'd0;
      else if (in_stream_s && win_s)   pix_cnt_r <= pix_inc_s;
      else                             pix_cnt_r <= pix_cnt_r;
    end
  end

  // A short frame wins over the clear that normally happens on LOAD entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            frame_err_r <= 1'b0;
    else if (short_s)      frame_err_r <= 1'b1;
    else if (load_entry_s) frame_err_r <= 1'b0;
    else if (uflow_s)      frame_err_r <= 1'b1;
    else                   frame_err_r <= frame_err_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_d1_r   <= 1'b0;
      uflow_d1_r <= 1'b0;
    end else begin
      win_d1_r   <= win_s;
      uflow_d1_r <= uflow_s;
    end
  end

`ifdef LCD_TEST_PATTERN_EN
  always_comb begin
    rel_x_s   = bus.pixel_xpos - x0_r;
    bar_idx_s = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(rel_x_s) >= k * BAR_W) bar_idx_s = 3'(k);
      else                            bar_idx_s = bar_idx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_d1_r  <= 16'h0000;
      test_d1_r <= 1'b0;
    end else begin
      bar_d1_r  <= bar_color(bar_idx_s);
      test_d1_r <= test_s;
    end
  end

  // fifo_q only becomes valid the clock after the read, so the final mux sits after it.
  always_comb begin
    if (!win_d1_r)       pix_s = BG_COLOR;
    else if (test_d1_r)  pix_s = bar_d1_r;
    else if (uflow_d1_r) pix_s = ERR_COLOR;
    else                 pix_s = bus.fifo_q;
  end
`else
  // fifo_q only becomes valid the clock after the read, so the final mux sits after it.
  always_comb begin
    if (!win_d1_r)       pix_s = BG_COLOR;
    else if (uflow_d1_r) pix_s = ERR_COLOR;
    else                 pix_s = bus.fifo_q;
  end
`endif

  assign bus.pixel_data   = pix_s;
  assign bus.fifo_rd_en   = rd_en_s;
  assign bus.fifo_rd_load = (state_r == ST_LOAD);
  assign frame_err        = frame_err_r;

endmodule

// File: tb/tb_lcd_frame_sched.sv
// Randomized bench for lcd_frame_sched with a scaled-down image (16x6) so whole
// frames fit in a short run; a frame-level reference model predicts every output.
module tb_lcd_frame_sched;
  localparam int          HI   = 16;
  localparam int          VI   = 6;
  localparam int          LC   = 4;
  localparam int          BW   = HI / 8;
  localparam logic [15:0] BG   = 16'h0000;
  localparam logic [15:0] ERRC = 16'hF800;
  localparam int P_WAIT = 0, P_LOAD = 1, P_RUN = 2, P_DONE = 3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] h_disp, v_disp;
  logic        frame_err;
`ifdef LCD_TEST_PATTERN_EN
  logic        test_en = 1'b0;
`endif

  lcd_frame_sched_if bus ();

  lcd_frame_sched #(.H_IMG(HI), .V_IMG(VI), .LOAD_CYC(LC), .BG_COLOR(BG), .ERR_COLOR(ERRC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef LCD_TEST_PATTERN_EN
    .test_en   (test_en),
`endif
    .h_disp    (h_disp),
    .v_disp    (v_disp),
    .frame_err (frame_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int rd_seen, load_seen;

  // reference model of the frame scheduler
  int          m_phase, m_load_left, m_cnt, m_area, m_x0, m_y0, m_w, m_h;
  bit          m_err, m_s1, m_s2, m_win_prev, m_uflow_prev, m_rd_prev, m_test_prev;
  logic [15:0] m_bar_prev;
  logic [15:0] fifo_val;
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit test_mode();
`ifdef LCD_TEST_PATTERN_EN
    return test_en;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_phase = P_WAIT; m_load_left = 0; m_cnt = 0; m_area = 0;
    m_x0 = 0; m_y0 = 0; m_w = 0; m_h = 0; m_err = 1'b0;
    m_s1 = 1'b0; m_s2 = 1'b0;
    m_win_prev = 1'b0; m_uflow_prev = 1'b0; m_rd_prev = 1'b0; m_test_prev = 1'b0;
    m_bar_prev = 16'h0000;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_val("rst_fifo_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    check_val("rst_fifo_rd_load", 32'(bus.fifo_rd_load), 32'd0);
    check_val("rst_frame_err", 32'(frame_err), 32'd0);
    check_val("rst_pixel_data", 32'(bus.pixel_data), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // the first edge after release samples the held vsync level
    m_s1 = bus.lcd_vs;
    m_s2 = 1'b0;
  endtask

  task automatic step(input bit req, input int x, input int y, input bit empty, input bit vs);
    logic [15:0] exp_pix;
    bit win, fall, exp_rd, tst;
    int bi;
    @(posedge clk);
    #1;
    if (m_rd_prev) begin
      fifo_val   = 16'($urandom);
      bus.fifo_q = fifo_val;
    end
    #1;
    if (!m_win_prev)       exp_pix = BG;
    else if (m_test_prev)  exp_pix = m_bar_prev;
    else if (m_uflow_prev) exp_pix = ERRC;
    else                   exp_pix = fifo_val;
    check_val("pixel_data", 32'(bus.pixel_data), 32'(exp_pix));
    check_val("fifo_rd_load", 32'(bus.fifo_rd_load), (m_phase == P_LOAD) ? 32'd1 : 32'd0);
    check_val("frame_err", 32'(frame_err), 32'(m_err));
    if (bus.fifo_rd_load) load_seen++;

    bus.data_req   = req;
    bus.pixel_xpos = 11'(x);
    bus.pixel_ypos = 11'(y);
    bus.fifo_empty = empty;
    bus.lcd_vs     = vs;
    #1;
    tst    = test_mode();
    win    = req && (x >= m_x0) && (x < m_x0 + m_w) && (y >= m_y0) && (y < m_y0 + m_h);
    exp_rd = (m_phase == P_RUN) && win && !empty && !tst;
    check_val("fifo_rd_en", 32'(bus.fifo_rd_en), 32'(exp_rd));
    if (bus.fifo_rd_en) rd_seen++;

    m_uflow_prev = (m_phase == P_RUN) && win && empty && !tst;
    m_win_prev   = win;
    m_rd_prev    = exp_rd;
    m_test_prev  = tst;
    if (win) begin
      bi = (x - m_x0) / BW;
      m_bar_prev = bars[(bi > 7) ? 7 : bi];
    end

    fall = m_s2 && !m_s1;
    case (m_phase)
      P_WAIT, P_DONE: if (fall) begin m_phase = P_LOAD; m_load_left = LC; m_err = 1'b0; end
      P_LOAD: begin
        m_load_left--;
        if (m_load_left == 0) begin m_phase = P_RUN; m_cnt = 0; end
      end
      P_RUN: begin
        if (fall) begin
          m_phase = P_LOAD; m_load_left = LC; m_err = 1'b1;
        end else begin
          if (m_uflow_prev) m_err = 1'b1;
          if (win) begin
            m_cnt++;
            if (m_cnt == m_area) m_phase = P_DONE;
          end
        end
      end
      default: m_phase = P_WAIT;
    endcase
    if (fall) begin
      m_x0   = (int'(h_disp) >= HI) ? (int'(h_disp) - HI) / 2 : 0;
      m_y0   = (int'(v_disp) >= VI) ? (int'(v_disp) - VI) / 2 : 0;
      m_w    = (int'(h_disp) >= HI) ? HI : int'(h_disp);
      m_h    = (int'(v_disp) >= VI) ? VI : int'(v_disp);
      m_area = m_w * m_h;
    end
    m_s2 = m_s1;
    m_s1 = vs;
  endtask

  // mode 0: FIFO never empty, 1: random empties, 2: three empties at (5..7, 2)
  task automatic frame(input int hd, input int vd, input int mode, input int stop_after, input int gap_pct);
    int n, w, h, exp_reads;
    bit e;
    h_disp = 11'(hd);
    v_disp = 11'(vd);
    rd_seen = 0;
    load_seen = 0;
    repeat (3)  step(1'b0, $urandom_range(30), $urandom_range(10), 1'b0, 1'b0);
    repeat (12) step(1'b0, $urandom_range(30), $urandom_range(10), 1'b0, 1'b1);
    check_val("load_len", 32'(load_seen), 32'(LC));
    n = 0;
    for (int y = 0; y < vd; y++) begin
      for (int x = 0; x < hd; x++) begin
        if (stop_after >= 0 && n >= stop_after) return;
        if ($urandom_range(99) < gap_pct) step(1'b0, $urandom_range(30), y, 1'b0, 1'b1);
        case (mode)
          1:       e = ($urandom_range(9) == 0);
          2:       e = (y == 2) && (x >= 5) && (x < 8);
          default: e = 1'b0;
        endcase
        step(1'b1, x, y, e, 1'b1);
        n++;
      end
      repeat (3) step(1'b0, $urandom_range(30), y, 1'b0, 1'b1);
    end
    repeat (4) step(1'b0, 0, 0, 1'b0, 1'b1);
    if (mode != 1) begin
      w = (hd >= HI) ? HI : hd;
      h = (vd >= VI) ? VI : vd;
      exp_reads = test_mode() ? 0 : (w * h - ((mode == 2) ? 3 : 0));
      check_val("frame_reads", 32'(rd_seen), 32'(exp_reads));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.lcd_vs     = 1'b1;
    bus.data_req   = 1'b0;
    bus.pixel_xpos = 11'd0;
    bus.pixel_ypos = 11'd0;
    bus.fifo_q     = 16'h0000;
    bus.fifo_empty = 1'b0;
    fifo_val       = 16'h0000;
    h_disp         = 11'd20;
    v_disp         = 11'd6;
    rd_seen        = 0;
    load_seen      = 0;
    #2;
    apply_reset();

    frame(20, 6, 0, -1, 0);    // centred, x0=2: 96 reads
    frame(20, 6, 2, -1, 10);   // three underflow pixels
    frame(20, 6, 0, -1, 0);    // error cleared at vsync
    frame(20, 6, 0, 40, 0);    // vsync arrives early
    frame(20, 6, 0, -1, 0);    // short-frame error carried through this frame
    frame(20, 6, 0, -1, 5);    // clean again
    frame(12, 4, 0, -1, 0);    // panel smaller than image: x0=y0=0, 48 reads
    frame(12, 9, 0, -1, 0);    // cropped width, centred height y0=1
    frame(21, 7, 1, -1, 20);   // odd sizes, random empties and gaps

    frame(20, 6, 0, 30, 0);    // reset while streaming
    apply_reset();
    rd_seen = 0;
    for (int i = 0; i < 40; i++) step(1'b1, 2 + (i % 16), 3, 1'b0, 1'b1);
    check_val("post_reset_reads", 32'(rd_seen), 32'd0);
    frame(20, 6, 0, -1, 0);

`ifdef LCD_TEST_PATTERN_EN
    test_en = 1'b1;
    frame(20, 6, 0, -1, 0);    // colour bars, no FIFO reads
    test_en = 1'b0;
    frame(20, 6, 0, -1, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
